// File: rtl/div11_check_gen.sv
// Serial mod-11 check-digit generator: accepts BCD digits MSB-first and emits the
// digit that makes the extended number divisible by 11.
//
// state | meaning
// ------+------------------------------------------------------------
// ACCUM | accepting digits, folding each into the running residue
// EMIT  | result registered and held until the consumer takes it
module div11_check_gen #(
  parameter int MAX_DIGITS = 4,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_digit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_digit,
  output logic [2:0]       out_err,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {ACCUM = 1'b0, EMIT = 1'b1} state_t;

  localparam logic [CNT_W:0] CNT_MAX = (CNT_W+1)'(MAX_DIGITS);
  localparam logic [CNT_W:0] CNT_SAT = (CNT_W+1)'(MAX_DIGITS + 1);

  state_t            state;
  logic [3:0]        residue;
  logic [CNT_W-1:0]  count;
  logic [1:0]        err;

  logic              bad_digit;
  logic [3:0]        d_eff;
  logic signed [4:0] t;
  logic [3:0]        r_next;
  logic [CNT_W:0]    cnt_inc;
  logic [CNT_W-1:0]  cnt_next;
  logic [1:0]        err_next;

  // 10 == -1 (mod 11), so appending digit d maps residue r to (d - r) mod 11
  always_comb begin
    bad_digit = (in_digit > 4'd9);
    d_eff     = bad_digit ? (in_digit & 4'h7) : in_digit;
    t         = $signed({1'b0, d_eff}) - $signed({1'b0, residue});
    r_next    = t[4] ? 4'($unsigned(t) + 5'd11) : t[3:0];
    cnt_inc   = {1'b0, count} + (CNT_W+1)'(1);
    cnt_next  = (cnt_inc > CNT_SAT) ? CNT_SAT[CNT_W-1:0] : cnt_inc[CNT_W-1:0];
    err_next  = err | {(cnt_inc > CNT_MAX), bad_digit};
  end

  assign in_ready = (state == ACCUM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      residue   <= '0;
      count     <= '0;
      err       <= '0;
      out_valid <= 1'b0;
      out_digit <= '0;
      out_err   <= '0;
      out_count <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            residue <= r_next;
            count   <= cnt_next;
            err     <= err_next;
            if (in_last) begin
              // residue 10 encodes naturally as 4'hA
              state     <= EMIT;
              out_valid <= 1'b1;
              out_digit <= r_next;
              out_err   <= {(r_next == 4'd10), err_next};
              out_count <= cnt_next;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            residue   <= '0;
            count     <= '0;
            err       <= '0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_div11_check_gen.sv
// Self-checking bench for div11_check_gen: directed scenarios plus randomized
// sequences compared against a whole-number mod-11 reference model.
module tb_div11_check_gen;

  localparam int MAX_DIGITS = 4;
  localparam int CNT_W      = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_digit = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [3:0]       out_digit;
  logic [2:0]       out_err;
  logic [CNT_W-1:0] out_count;

  div11_check_gen #(.MAX_DIGITS(MAX_DIGITS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_digit(in_digit), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_digit(out_digit), .out_err(out_err),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]       seq_d[16];
  int               seq_n;
  logic             cap_valid;
  logic [3:0]       cap_digit;
  logic [2:0]       cap_err;
  logic [CNT_W-1:0] cap_count;
  logic [3:0]       exp_digit;
  logic [2:0]       exp_err;
  logic [CNT_W-1:0] exp_count;

  // Reference: treat the digits as a decimal integer and take it mod 11.
  task automatic compute_expected();
    longint v = 0;
    bit bad = 0;
    int r;
    for (int i = 0; i < seq_n; i++) begin
      if (seq_d[i] > 9) bad = 1;
      v = v * 10 + longint'(seq_d[i]);
    end
    r = int'(v % 11);
    exp_digit = 4'(r);
    exp_count = CNT_W'((seq_n > MAX_DIGITS) ? MAX_DIGITS + 1 : seq_n);
    exp_err   = {(r == 10), (seq_n > MAX_DIGITS), bad};
  endtask

  // Feeds seq_d[0..seq_n-1]; captures outputs #1 after the last transfer edge.
  task automatic run_seq(input int gap_max);
    int w;
    for (int i = 0; i < seq_n; i++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_digit = seq_d[i];
      in_last  = (i == seq_n - 1);
      w = 0;
      while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
      if (w == 20) begin
        n_checks++; n_fail++;
        $display("FAIL in_ready_timeout: in_ready stayed %b, required 1", in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    cap_valid = out_valid;
    cap_digit = out_digit;
    cap_err   = out_err;
    cap_count = out_count;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_digit !== 4'd0) begin n_fail++; $display("FAIL reset_out_digit: got %h want 0", out_digit); end
    n_checks++; if (out_err !== 3'd0) begin n_fail++; $display("FAIL reset_out_err: got %b want 000", out_err); end
    n_checks++; if (out_count !== 3'd0) begin n_fail++; $display("FAIL reset_out_count: got %0d want 0", out_count); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    seq_d[0] = 1; seq_d[1] = 2; seq_d[2] = 3; seq_d[3] = 4; seq_n = 4;
    out_ready = 1'b1;
    run_seq(0);
    n_checks++; if (cap_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: out_valid %b want 1", cap_valid); end
    n_checks++; if (cap_digit !== 4'd2) begin n_fail++; $display("FAIL basic_digit: got %h want 2", cap_digit); end
    n_checks++; if (cap_err !== 3'b000) begin n_fail++; $display("FAIL basic_err: got %b want 000", cap_err); end
    n_checks++; if (cap_count !== 3'd4) begin n_fail++; $display("FAIL basic_count: got %0d want 4", cap_count); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_release: out_valid %b in_ready %b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    seq_d[0] = 9; seq_d[1] = 0; seq_d[2] = 9; seq_n = 3;
    run_seq(0);
    n_checks++; if (cap_digit !== 4'd7) begin n_fail++; $display("FAIL b2b_909_digit: got %h want 7", cap_digit); end
    n_checks++; if (cap_err !== 3'b000 || cap_count !== 3'd3) begin n_fail++; $display("FAIL b2b_909_err_count: got %b/%0d want 000/3", cap_err, cap_count); end
    release_out();
    seq_d[0] = 5; seq_n = 1;
    run_seq(0);
    n_checks++; if (cap_digit !== 4'd5) begin n_fail++; $display("FAIL b2b_single_digit: got %h want 5", cap_digit); end
    n_checks++; if (cap_count !== 3'd1) begin n_fail++; $display("FAIL b2b_single_count: got %0d want 1", cap_count); end
    release_out();
  endtask

  task automatic test_residue10();
    seq_d[0] = 1; seq_d[1] = 0; seq_n = 2;
    run_seq(1);
    n_checks++; if (cap_digit !== 4'hA) begin n_fail++; $display("FAIL r10_digit: got %h want A", cap_digit); end
    n_checks++; if (cap_err !== 3'b100) begin n_fail++; $display("FAIL r10_err: got %b want 100", cap_err); end
    release_out();
    seq_d[0] = 0; seq_d[1] = 0; seq_d[2] = 0; seq_d[3] = 0; seq_n = 4;
    run_seq(1);
    n_checks++; if (cap_digit !== 4'd0 || cap_err !== 3'b000) begin n_fail++; $display("FAIL zeros: got %h/%b want 0/000", cap_digit, cap_err); end
    release_out();
  endtask

  task automatic test_errors();
    seq_d[0] = 1; seq_d[1] = 12; seq_d[2] = 3; seq_n = 3;
    run_seq(0);
    n_checks++; if (cap_err[1:0] !== 2'b01) begin n_fail++; $display("FAIL err_nonbcd: got %b want x01", cap_err); end
    n_checks++; if (cap_count !== 3'd3) begin n_fail++; $display("FAIL err_nonbcd_count: got %0d want 3", cap_count); end
    release_out();
    for (int i = 0; i < 5; i++) seq_d[i] = 1;
    seq_n = 5;
    run_seq(0);
    n_checks++; if (cap_err !== 3'b010) begin n_fail++; $display("FAIL err_overflow: got %b want 010", cap_err); end
    n_checks++; if (cap_count !== 3'd5) begin n_fail++; $display("FAIL err_overflow_count: got %0d want 5", cap_count); end
    n_checks++; if (cap_digit !== 4'd1) begin n_fail++; $display("FAIL err_overflow_digit: got %h want 1", cap_digit); end
    release_out();
  endtask

  task automatic test_backpressure();
    seq_d[0] = 1; seq_d[1] = 2; seq_d[2] = 3; seq_d[3] = 4; seq_n = 4;
    run_seq(0);
    for (int k = 0; k < 3; k++) begin
      in_valid = k[0] ? 1'b0 : 1'b1;
      in_digit = 4'd9;
      in_last  = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_digit !== 4'd2 || out_err !== 3'b000 || out_count !== 3'd4 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: valid %b digit %h err %b count %0d in_ready %b want 1 2 000 4 0",
                 k, out_valid, out_digit, out_err, out_count, in_ready);
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release: out_valid %b in_ready %b want 0 1", out_valid, in_ready); end
    seq_d[0] = 5; seq_n = 1;
    run_seq(0);
    n_checks++; if (cap_digit !== 4'd5 || cap_count !== 3'd1) begin n_fail++; $display("FAIL hold_after: got %h/%0d want 5/1", cap_digit, cap_count); end
    release_out();
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_last = 1'b0;
    in_digit = 4'd1; @(posedge clk); #1;
    in_digit = 4'd2; @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1; #2;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 3'd0) begin n_fail++; $display("FAIL rst_mid_seq: in_ready %b out_valid %b count %0d want 1 0 0", in_ready, out_valid, out_count); end
    @(posedge clk); #1; rst = 1'b0;
    seq_d[0] = 7; seq_d[1] = 3; seq_n = 2;
    run_seq(0);
    #2; rst = 1'b1; #1;
    n_checks++; if (out_valid !== 1'b0 || out_digit !== 4'd0 || out_err !== 3'd0 || out_count !== 3'd0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_emit: valid %b digit %h err %b count %0d in_ready %b want 0 0 000 0 1", out_valid, out_digit, out_err, out_count, in_ready);
    end
    @(posedge clk); #1; rst = 1'b0;
    seq_d[0] = 1; seq_d[1] = 2; seq_d[2] = 3; seq_d[3] = 4; seq_n = 4;
    run_seq(0);
    n_checks++; if (cap_digit !== 4'd2 || cap_count !== 3'd4) begin n_fail++; $display("FAIL rst_fresh: got %h/%0d want 2/4", cap_digit, cap_count); end
    release_out();
  endtask

  task automatic test_random();
    for (int s = 0; s < 60; s++) begin
      seq_n = $urandom_range(1, 6);
      for (int i = 0; i < seq_n; i++)
        seq_d[i] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      compute_expected();
      run_seq(2);
      n_checks++; if (cap_valid !== 1'b1) begin n_fail++; $display("FAIL rand%0d_valid: got %b want 1", s, cap_valid); end
      n_checks++; if (cap_count !== exp_count) begin n_fail++; $display("FAIL rand%0d_count: got %0d want %0d", s, cap_count, exp_count); end
      n_checks++;
      if (exp_err[0]) begin
        if (cap_err[1:0] !== exp_err[1:0]) begin n_fail++; $display("FAIL rand%0d_err: got %b want x%b", s, cap_err, exp_err[1:0]); end
      end else if (cap_err !== exp_err || cap_digit !== exp_digit) begin
        n_fail++; $display("FAIL rand%0d_result: got %h/%b want %h/%b", s, cap_digit, cap_err, exp_digit, exp_err);
      end
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_residue10();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
